// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: request formats, opcodes
// and the signed immediate limits each format can represent.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_L    = 3'd3,
    FMT_B    = 3'd4,
    FMT_JAL  = 3'd5,
    FMT_JALR = 3'd6,
    FMT_HALT = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_L    = 7'b0000011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [31:0] HALT_WORD = 32'h0000_007F;

  localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
  localparam logic signed [31:0] SHAMT_MAX = 32'sd31;
  localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;
  localparam logic signed [31:0] IMMJ_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMMJ_MAX  = 32'sd1048574;

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: turns one field-level request into a 32-bit RV32I
// word and flags whether the immediate fits the chosen format.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  fmt_e               fmt,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic [4:0]         rd,
  input  logic [4:0]         rs1,
  input  logic [4:0]         rs2,
  input  logic signed [31:0] imm,
  output logic [31:0]        word,
  output logic               range_ok
);

  logic is_shift;
  logic in12;

  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign in12     = (imm >= IMM12_MIN) && (imm <= IMM12_MAX);

  always_comb begin
    word     = 32'h0;
    range_ok = 1'b1;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, OP_R};
      FMT_I: begin
        if (is_shift) begin
          word     = {funct7, imm[4:0], rs1, funct3, rd, OP_I};
          range_ok = (imm >= 32'sd0) && (imm <= SHAMT_MAX);
        end else begin
          word     = {imm[11:0], rs1, funct3, rd, OP_I};
          range_ok = in12;
        end
      end
      FMT_L: begin
        word     = {imm[11:0], rs1, funct3, rd, OP_L};
        range_ok = in12;
      end
      FMT_JALR: begin
        word     = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
        range_ok = in12;
      end
      FMT_S: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_S};
        range_ok = in12;
      end
      FMT_B: begin
        word     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_B};
        range_ok = !imm[0] && (imm >= IMMB_MIN) && (imm <= IMMB_MAX);
      end
      FMT_JAL: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        range_ok = !imm[0] && (imm >= IMMJ_MIN) && (imm <= IMMJ_MAX);
      end
      FMT_HALT: word = HALT_WORD;
      default: begin
        word     = 32'h0;
        range_ok = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential RV32I encoder: accepts field requests in LOAD, packs them and writes
// consecutive words to instruction memory one cycle after acceptance.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_fmt,
  input  logic [2:0]        req_funct3,
  input  logic [6:0]        req_funct7,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAP  = {1'b1, {ADDR_W{1'b0}}};

  state_e            state, state_nxt;
  logic [31:0]       word_p0;
  logic              range_ok_p0;
  logic              acc_p0, full_p0, halt_p0, wr_p0;
  logic [ADDR_W-1:0] addr_q;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  instr_pack u_pack (
    .fmt      (fmt_e'(req_fmt)),
    .funct3   (req_funct3),
    .funct7   (req_funct7),
    .rd       (req_rd),
    .rs1      (req_rs1),
    .rs2      (req_rs2),
    .imm      (signed'(req_imm)),
    .word     (word_p0),
    .range_ok (range_ok_p0)
  );

  // p0: acceptance decision; a full image or bad immediate never reaches imem
  assign acc_p0  = req_valid && (state == S_LOAD);
  assign full_p0 = (word_count == CAP);
  assign halt_p0 = (req_fmt == FMT_HALT);
  assign wr_p0   = acc_p0 && !full_p0 && range_ok_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        if (start)                     state_nxt = S_LOAD;
        else if (acc_p0 && full_p0)    state_nxt = S_DONE;
        else if (wr_p0 && halt_p0)     state_nxt = S_DONE;
      end
      S_DONE: if (start) state_nxt = S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // p1: registered write port; a restart still lets the accepted word land
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      addr_p1    <= BASE;
      wdata_p1   <= 32'h0;
      addr_q     <= BASE;
      word_count <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
    end else begin
      vld_p1 <= wr_p0;
      if (wr_p0) begin
        addr_p1  <= addr_q;
        wdata_p1 <= word_p0;
      end
      if (start) begin
        addr_q     <= BASE;
        word_count <= '0;
        err        <= 1'b0;
        done       <= 1'b0;
      end else begin
        if (wr_p0) begin
          addr_q     <= addr_q + 1'b1;
          word_count <= word_count + 1'b1;
        end
        if (acc_p0 && (full_p0 || !range_ok_p0)) err <= 1'b1;
        if (wr_p0 && halt_p0) done <= 1'b1;
      end
    end
  end

  assign imem_we    = vld_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;
  assign busy       = (state == S_LOAD);
  assign req_ready  = (state == S_LOAD);

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Sequential RV32I instruction encoder: the inverse of the opcode control decoder. It accepts field-level instruction requests over a valid/ready handshake, packs each into a 32-bit word, and writes consecutive words into instruction memory. It sits between the boot/test loader and the imem write port, producing program images that the datapath and control decoder then execute.

Parameters:
ADDR_W, 8, imem word-address width; capacity is 2^ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
start  in  1  one-cycle pulse: begin new program load
req_valid  in  1  request present
req_ready  out  1  encoder accepts request this cycle
req_fmt  in  3  0=R 1=I 2=S 3=L 4=B 5=JAL 6=JALR 7=HALT
req_funct3  in  3  funct3 field
req_funct7  in  7  funct7 (R, I-shift)
req_rd  in  5  destination reg
req_rs1  in  5  source reg 1
req_rs2  in  5  source reg 2
req_imm  in  32  signed immediate / byte offset
imem_we  out  1  write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded word
busy  out  1  state is LOAD
done  out  1  HALT written; held until start or rst
err  out  1  sticky error; cleared by start or rst
word_count  out  ADDR_W+1  words written since start

Behaviour:
- Reset (async, rst=1): state IDLE; req_ready, imem_we, busy, done, err = 0; imem_addr = BASE_ADDR; imem_wdata = 0; word_count = 0.
- FSM: IDLE -start-> LOAD; LOAD -HALT accepted-> DONE; LOAD -capacity overflow-> DONE with err=1; DONE -start-> LOAD. start in LOAD restarts: address/count reset, err/done cleared, no pending write lost (write of the word accepted the same cycle still occurs).
- req_ready = 1 only in LOAD. Accept = req_valid & req_ready. One request per cycle max; no back-pressure from imem.
- Latency: accepted in cycle N -> imem_we=1 with imem_addr/imem_wdata in cycle N+1, one cycle wide. Address increments by 1 per written word; word_count increments with each write.
- Opcodes: R 0110011, I 0010011, S 0100011, L 0000011, B 1100011, JAL 1101111, JALR 1100111 (funct3 forced 000), HALT word = 0x0000007F.
- Packing: R funct7|rs2|rs1|f3|rd|op; I/L/JALR imm[11:0]|rs1|f3|rd|op; I with f3=001/101: funct7|imm[4:0]|rs1|f3|rd|op; S imm[11:5]|rs2|rs1|f3|imm[4:0]|op; B imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op; JAL imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Range checks (signed): I/L/S/JALR [-2048,2047]; shifts [0,31]; B even, [-4096,4094]; JAL even, [-1048576,1048574]. Violation: request consumed, no write, err=1, stays in LOAD.
- Capacity: request accepted when word_count == 2^ADDR_W -> no write, err=1, go to DONE. HALT counts as a word; if no room, same overflow rule.
- Requests with req_valid in IDLE/DONE are ignored (not consumed).

Decomposition:
- Shared package: format enum (FMT_R..FMT_HALT), opcode constants, HALT_WORD, immediate limit constants.
- One sub-module natural: instr_pack (combinational fields -> 32-bit word plus range_ok flag); FSM, counters and output register stay in instr_encoder.

Test Plan:
- start; R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> cycle+1 imem_we=1, addr=0, wdata=0x002081B3, word_count=1.
- back-to-back I rd=5 rs1=0 imm=-1 then S rs1=1 rs2=2 f3=2 imm=8 -> wdata 0xFFF00293 @0, 0x0020A423 @1, consecutive cycles.
- B rs1=1 rs2=2 f3=0 imm=-8 -> 0xFE208CE3; then B imm=3 -> no write, err=1, busy stays 1.
- HALT after 2 words -> wdata=0x0000007F @2, done=1, req_ready=0, word_count=3; further req_valid ignored.
- ADDR_W=2: 5 I requests -> 4 writes, 5th sets err=1, state DONE, no 5th write.
- rst asserted mid-LOAD between accept and write -> imem_we never pulses, all outputs at reset values immediately.
